// File: rtl/mem_arbiter_pkg.sv
// Constants and encodings shared by the memory arbiter and the two caches.
package mem_arbiter_pkg;

    localparam int MEM_DATA_BITS = 128;
    localparam int BEATS         = 4;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RRESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-requester round-robin selector: a lone requester always wins, a tie goes
// to the requester named by the priority pointer.
module rr_pick2 (
    input  logic i_ic_val,
    input  logic i_dc_val,
    input  logic i_prio,
    output logic o_winner
);
    import mem_arbiter_pkg::*;

    always_comb begin
        o_winner = i_prio;
        if (i_ic_val && !i_dc_val) begin
            o_winner = OWN_IC;
        end else if (i_dc_val && !i_ic_val) begin
            o_winner = OWN_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single backing-memory port between the I-cache and D-cache,
// holding the grant for a whole line transaction (request plus all beats).
module mem_arbiter #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = mem_arbiter_pkg::MEM_DATA_BITS,
    parameter int BEATS         = mem_arbiter_pkg::BEATS
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       ic_req_val,
    output logic                       ic_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
    output logic                       ic_resp_val,
    output logic [MEM_DATA_BITS-1:0]   ic_resp_data,

    input  logic                       dc_req_val,
    output logic                       dc_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
    input  logic                       dc_req_rw,
    input  logic                       dc_req_data_valid,
    output logic                       dc_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                       dc_resp_val,
    output logic [MEM_DATA_BITS-1:0]   dc_resp_data,

    output logic                       mem_req_val,
    input  logic                       mem_req_rdy,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_val,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);
    import mem_arbiter_pkg::*;

    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic                 r_owner;
    logic                 w_owner_next;
    logic                 r_prio;
    logic                 w_prio_next;
    logic [BEAT_BITS-1:0] r_beat;
    logic [BEAT_BITS-1:0] w_beat_next;

    logic w_winner;
    logic w_win_val;
    logic w_win_rw;
    logic w_idle;
    logic w_wdata;
    logic w_rresp;
    logic w_req_fire;
    logic w_data_fire;
    logic w_resp_beat;
    logic w_last_beat;

    rr_pick2 u_pick (
        .i_ic_val (ic_req_val),
        .i_dc_val (dc_req_val),
        .i_prio   (r_prio),
        .o_winner (w_winner)
    );

    // The I-cache port is read-only, so only a D-cache winner can request a write.
    assign w_win_val = (w_winner == OWN_DC) ? dc_req_val : ic_req_val;
    assign w_win_rw  = (w_winner == OWN_DC) && dc_req_rw;

    assign w_idle  = !reset && (r_state == IDLE);
    assign w_wdata = !reset && (r_state == WDATA);
    assign w_rresp = !reset && (r_state == RRESP);

    assign mem_req_addr      = (w_winner == OWN_DC) ? dc_req_addr : ic_req_addr;
    assign mem_req_rw        = w_win_rw;
    assign mem_req_val       = w_idle && w_win_val;
    assign ic_req_rdy        = w_idle && (w_winner == OWN_IC) && mem_req_rdy;
    assign dc_req_rdy        = w_idle && (w_winner == OWN_DC) && mem_req_rdy;

    assign mem_req_data_bits  = dc_req_data_bits;
    assign mem_req_data_mask  = dc_req_data_mask;
    assign mem_req_data_valid = w_wdata && dc_req_data_valid;
    assign dc_req_data_ready  = w_wdata && mem_req_data_ready;

    // Response data fans out to both caches; only the owner sees a valid beat.
    assign ic_resp_data = mem_resp_data;
    assign dc_resp_data = mem_resp_data;
    assign ic_resp_val  = w_rresp && (r_owner == OWN_IC) && mem_resp_val;
    assign dc_resp_val  = w_rresp && (r_owner == OWN_DC) && mem_resp_val;

    assign w_req_fire  = mem_req_val && mem_req_rdy;
    assign w_data_fire = mem_req_data_valid && dc_req_data_ready;
    assign w_resp_beat = w_rresp && mem_resp_val;
    assign w_last_beat = (r_beat == LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= OWN_IC;
            r_prio  <= OWN_DC;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_prio  <= w_prio_next;
            r_beat  <= w_beat_next;
        end
    end

    // Priority only moves on an actual request fire, so a withdrawn request keeps its turn.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_prio_next  = r_prio;
        w_beat_next  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_owner_next = w_winner;
                    w_prio_next  = ~w_winner;
                    w_beat_next  = '0;
                    w_state_next = w_win_rw ? WDATA : RRESP;
                end
            end
            WDATA: begin
                if (w_data_fire) begin
                    if (w_last_beat) begin
                        w_state_next = IDLE;
                        w_beat_next  = '0;
                    end else begin
                        w_beat_next = r_beat + 1'b1;
                    end
                end
            end
            RRESP: begin
                if (w_resp_beat) begin
                    if (w_last_beat) begin
                        w_state_next = IDLE;
                        w_beat_next  = '0;
                    end else begin
                        w_beat_next = r_beat + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed traffic queues expected memory-side
// and cache-side events, and a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    localparam int K_REQ   = 0;
    localparam int K_WDATA = 1;
    localparam int K_IC    = 2;
    localparam int K_DC    = 3;

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } expect_t;

    expect_t expQ[$];
    int checks = 0;
    int errors = 0;

    logic          clk;
    logic          reset;
    logic          ic_req_val;
    logic          ic_req_rdy;
    logic [AW-1:0] ic_req_addr;
    logic          ic_resp_val;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_val;
    logic          dc_req_rdy;
    logic [AW-1:0] dc_req_addr;
    logic          dc_req_rw;
    logic          dc_req_data_valid;
    logic          dc_req_data_ready;
    logic [DW-1:0] dc_req_data_bits;
    logic [MW-1:0] dc_req_data_mask;
    logic          dc_resp_val;
    logic [DW-1:0] dc_resp_data;
    logic          mem_req_val;
    logic          mem_req_rdy;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_rw;
    logic          mem_req_data_valid;
    logic          mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_val;
    logic [DW-1:0] mem_resp_data;

    logic [7:0] wdata [4];

    mem_arbiter #(
        .MEM_ADDR_BITS (AW),
        .MEM_DATA_BITS (DW),
        .BEATS         (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ic_req_val         (ic_req_val),
        .ic_req_rdy         (ic_req_rdy),
        .ic_req_addr        (ic_req_addr),
        .ic_resp_val        (ic_resp_val),
        .ic_resp_data       (ic_resp_data),
        .dc_req_val         (dc_req_val),
        .dc_req_rdy         (dc_req_rdy),
        .dc_req_addr        (dc_req_addr),
        .dc_req_rw          (dc_req_rw),
        .dc_req_data_valid  (dc_req_data_valid),
        .dc_req_data_ready  (dc_req_data_ready),
        .dc_req_data_bits   (dc_req_data_bits),
        .dc_req_data_mask   (dc_req_data_mask),
        .dc_resp_val        (dc_resp_val),
        .dc_resp_data       (dc_resp_data),
        .mem_req_val        (mem_req_val),
        .mem_req_rdy        (mem_req_rdy),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_val       (mem_resp_val),
        .mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic string kindName(int k);
        case (k)
            K_REQ:   return "mem_req";
            K_WDATA: return "mem_wdata";
            K_IC:    return "ic_resp";
            default: return "dc_resp";
        endcase
    endfunction

    task automatic expectEvent(input int kind, input logic [DW-1:0] data, input logic [MW-1:0] mask);
        expect_t e;
        e.kind = kind;
        e.data = data;
        e.mask = mask;
        expQ.push_back(e);
    endtask

    task automatic scoreCheck(input int kind, input logic [DW-1:0] data, input logic [MW-1:0] mask);
        expect_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: got unexpected event data=%h mask=%h, required no event",
                     kindName(kind), data, mask);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.data !== data || e.mask !== mask) begin
                errors++;
                $display("[TB] FAIL %s: got data=%h mask=%h, required %s data=%h mask=%h",
                         kindName(kind), data, mask, kindName(e.kind), e.data, e.mask);
            end
        end
    endtask

    // Monitor: every handshake or response beat the DUT presents is matched in order.
    always @(negedge clk) begin
        if (mem_req_val && mem_req_rdy)
            scoreCheck(K_REQ, DW'({mem_req_rw, mem_req_addr}), '0);
        if (mem_req_data_valid && mem_req_data_ready)
            scoreCheck(K_WDATA, mem_req_data_bits, mem_req_data_mask);
        if (ic_resp_val)
            scoreCheck(K_IC, ic_resp_data, '0);
        if (dc_resp_val)
            scoreCheck(K_DC, dc_resp_data, '0);
    end

    task automatic checkOutput(input string name, input logic actual, input logic required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, required);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic respVal, input logic [DW-1:0] respData);
        mem_resp_val  = respVal;
        mem_resp_data = respData;
        stepClock();
        mem_resp_val  = 1'b0;
    endtask

    // Four response beats with one idle cycle before the third beat.
    task automatic readBeats(input int kind, input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) applyStimulus(1'b0, '0);
            expectEvent(kind, DW'(base) + DW'(i), '0);
            applyStimulus(1'b1, DW'(base) + DW'(i));
        end
    endtask

    initial begin
        wdata[0] = 8'h11;
        wdata[1] = 8'h22;
        wdata[2] = 8'h33;
        wdata[3] = 8'h44;

        reset              = 1'b1;
        ic_req_val         = 1'b1;
        ic_req_addr        = '0;
        dc_req_val         = 1'b1;
        dc_req_addr        = '0;
        dc_req_rw          = 1'b0;
        dc_req_data_valid  = 1'b1;
        dc_req_data_bits   = '0;
        dc_req_data_mask   = '0;
        mem_req_rdy        = 1'b1;
        mem_req_data_ready = 1'b1;
        mem_resp_val       = 1'b1;
        mem_resp_data      = '0;

        // Reset holds every valid and ready low even with all inputs active.
        #12;
        checkOutput("rst_mem_req_val", mem_req_val, 1'b0);
        checkOutput("rst_ic_req_rdy", ic_req_rdy, 1'b0);
        checkOutput("rst_dc_req_rdy", dc_req_rdy, 1'b0);
        checkOutput("rst_mem_data_valid", mem_req_data_valid, 1'b0);
        checkOutput("rst_dc_data_ready", dc_req_data_ready, 1'b0);
        checkOutput("rst_ic_resp_val", ic_resp_val, 1'b0);
        checkOutput("rst_dc_resp_val", dc_resp_val, 1'b0);
        ic_req_val         = 1'b0;
        dc_req_val         = 1'b0;
        dc_req_data_valid  = 1'b0;
        mem_req_rdy        = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_val       = 1'b0;
        reset              = 1'b0;
        stepClock();

        $display("[TB] IC-only read with stray response in IDLE");
        ic_req_val    = 1'b1;
        ic_req_addr   = 28'h0000123;
        mem_resp_val  = 1'b1;
        mem_resp_data = DW'(8'hEE);
        #1;
        checkOutput("ic_mem_req_val", mem_req_val, 1'b1);
        checkOutput("ic_rdy_no_mem_rdy", ic_req_rdy, 1'b0);
        checkOutput("idle_stray_ic_resp", ic_resp_val, 1'b0);
        checkOutput("idle_stray_dc_resp", dc_resp_val, 1'b0);
        stepClock();
        mem_resp_val = 1'b0;
        mem_req_rdy  = 1'b1;
        expectEvent(K_REQ, DW'({1'b0, 28'h0000123}), '0);
        #1;
        checkOutput("ic_only_ic_rdy", ic_req_rdy, 1'b1);
        checkOutput("ic_only_dc_rdy", dc_req_rdy, 1'b0);
        stepClock();
        ic_req_val  = 1'b0;
        mem_req_rdy = 1'b0;
        readBeats(K_IC, 8'hA0);

        $display("[TB] simultaneous requests");
        ic_req_val  = 1'b1;
        ic_req_addr = 28'h0AAAAAA;
        dc_req_val  = 1'b1;
        dc_req_addr = 28'h0BBBBBB;
        dc_req_rw   = 1'b0;
        mem_req_rdy = 1'b1;
        expectEvent(K_REQ, DW'({1'b0, 28'h0BBBBBB}), '0);
        #1;
        checkOutput("both_dc_rdy", dc_req_rdy, 1'b1);
        checkOutput("both_ic_rdy", ic_req_rdy, 1'b0);
        stepClock();
        mem_req_rdy = 1'b0;
        #1;
        checkOutput("rresp_ic_rdy", ic_req_rdy, 1'b0);
        checkOutput("rresp_dc_rdy", dc_req_rdy, 1'b0);
        readBeats(K_DC, 8'hB0);
        mem_req_rdy = 1'b1;
        expectEvent(K_REQ, DW'({1'b0, 28'h0AAAAAA}), '0);
        #1;
        checkOutput("rr_ic_rdy", ic_req_rdy, 1'b1);
        checkOutput("rr_dc_rdy", dc_req_rdy, 1'b0);
        stepClock();
        ic_req_val  = 1'b0;
        dc_req_val  = 1'b0;
        mem_req_rdy = 1'b0;
        readBeats(K_IC, 8'hC0);

        $display("[TB] DC write with toggling data ready and stray response");
        dc_req_val  = 1'b1;
        dc_req_addr = 28'h0000456;
        dc_req_rw   = 1'b1;
        mem_req_rdy = 1'b1;
        expectEvent(K_REQ, DW'({1'b1, 28'h0000456}), '0);
        stepClock();
        dc_req_val  = 1'b0;
        dc_req_rw   = 1'b0;
        ic_req_val  = 1'b1;
        ic_req_addr = 28'h0000789;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 16 && k < 4; c++) begin
                dc_req_data_valid  = 1'b1;
                dc_req_data_bits   = DW'(wdata[k]);
                dc_req_data_mask   = '1;
                mem_req_data_ready = (c % 2 == 1);
                mem_resp_val       = (c == 2);
                mem_resp_data      = DW'(8'h5A);
                #1;
                checkOutput("wdata_ic_rdy", ic_req_rdy, 1'b0);
                checkOutput("wdata_mem_req_val", mem_req_val, 1'b0);
                if (c == 2) begin
                    checkOutput("wdata_stray_ic_resp", ic_resp_val, 1'b0);
                    checkOutput("wdata_stray_dc_resp", dc_resp_val, 1'b0);
                end
                if (mem_req_data_ready) expectEvent(K_WDATA, DW'(wdata[k]), '1);
                stepClock();
                if (mem_req_data_ready) k++;
            end
        end
        mem_resp_val       = 1'b0;
        mem_req_data_ready = 1'b1;
        expectEvent(K_REQ, DW'({1'b0, 28'h0000789}), '0);
        #1;
        checkOutput("idle_mem_data_valid", mem_req_data_valid, 1'b0);
        checkOutput("idle_dc_data_ready", dc_req_data_ready, 1'b0);
        checkOutput("after_write_ic_rdy", ic_req_rdy, 1'b1);
        stepClock();
        dc_req_data_valid  = 1'b0;
        mem_req_data_ready = 1'b0;
        ic_req_val         = 1'b0;
        mem_req_rdy        = 1'b0;
        readBeats(K_IC, 8'hD0);

        $display("[TB] reset in the middle of a DC read");
        dc_req_val  = 1'b1;
        dc_req_addr = 28'h0000321;
        mem_req_rdy = 1'b1;
        expectEvent(K_REQ, DW'({1'b0, 28'h0000321}), '0);
        stepClock();
        dc_req_val  = 1'b0;
        mem_req_rdy = 1'b0;
        expectEvent(K_DC, DW'(8'hE0), '0);
        applyStimulus(1'b1, DW'(8'hE0));
        expectEvent(K_DC, DW'(8'hE1), '0);
        applyStimulus(1'b1, DW'(8'hE1));
        mem_resp_val  = 1'b1;
        mem_resp_data = DW'(8'hE2);
        #1;
        checkOutput("pre_reset_dc_resp", dc_resp_val, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_dc_resp", dc_resp_val, 1'b0);
        checkOutput("mid_reset_ic_resp", ic_resp_val, 1'b0);
        ic_req_val  = 1'b1;
        ic_req_addr = 28'h0000654;
        dc_req_val  = 1'b1;
        dc_req_addr = 28'h0000ABC;
        mem_req_rdy = 1'b1;
        #1;
        checkOutput("mid_reset_mem_req_val", mem_req_val, 1'b0);
        checkOutput("mid_reset_dc_rdy", dc_req_rdy, 1'b0);
        mem_resp_val = 1'b0;
        stepClock();
        expectEvent(K_REQ, DW'({1'b0, 28'h0000ABC}), '0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("post_reset_dc_rdy", dc_req_rdy, 1'b1);
        checkOutput("post_reset_ic_rdy", ic_req_rdy, 1'b0);
        stepClock();
        ic_req_val  = 1'b0;
        dc_req_val  = 1'b0;
        mem_req_rdy = 1'b0;
        readBeats(K_DC, 8'hF0);

        stepClock();
        stepClock();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_events: got %0d expected events never seen, required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
